// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with sequential increment, redirect
// input backed by a one-entry pending-redirect buffer, and a RUN/HALTED
// state machine that only reset can leave.
// Optional performance counters are built when PC_UNIT_PERF_EN is defined;
// otherwise stall_cycles and redirect_count are tied to zero.
module pc_unit #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0,
    parameter logic [WIDTH-1:0]   STEP      = WIDTH'(2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_en,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_req,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_seq,
    output logic             fetch_valid,
    output logic             redirect_pending,
    output logic             halted,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      redirect_count
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_v_q, pend_v_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;

    // Link value / sequential successor; wraps modulo 2^WIDTH.
    assign pc_seq = pc_q + STEP;

    // Next-state: redirect first, then buffered redirect, then halt, then step.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        unique case (state_q)
            ST_RUN: begin
                if (redirect_en && !stall_en) begin
                    // Immediate redirect also discards any older buffered one.
                    pc_d     = redirect_pc;
                    pend_v_d = 1'b0;
                end else if (redirect_en && stall_en) begin
                    // Stalled: remember the newest target until release.
                    pend_pc_d = redirect_pc;
                    pend_v_d  = 1'b1;
                end else if (!stall_en && pend_v_q) begin
                    // Current fetch is wrong-path; any halt here is squashed.
                    pc_d     = pend_pc_q;
                    pend_v_d = 1'b0;
                end else if (!stall_en && halt_req) begin
                    // PC stays on the HLT address.
                    state_d = ST_HALTED;
                end else if (!stall_en) begin
                    pc_d = pc_seq;
                end
            end
            ST_HALTED: begin
                pend_v_d = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Architectural state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_VEC;
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign pc_out           = pc_q;
    assign fetch_valid      = (state_q == ST_RUN) && !pend_v_q;
    assign redirect_pending = pend_v_q;
    assign halted           = (state_q == ST_HALTED);

`ifdef PC_UNIT_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    // Saturating increment so counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Counters only observe RUN cycles.
    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        redirect_count_d = redirect_count_q;
        if (state_q == ST_RUN) begin
            if (stall_en)    stall_cycles_d   = sat_inc(stall_cycles_q);
            if (redirect_en) redirect_count_d = sat_inc(redirect_count_q);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign stall_cycles   = stall_cycles_q;
    assign redirect_count = redirect_count_q;
`else
    assign stall_cycles   = '0;
    assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit (WIDTH=16, RESET_VEC=0, STEP=2).
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_en;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic [15:0] pc_out;
    logic [15:0] pc_seq;
    logic        fetch_valid;
    logic        redirect_pending;
    logic        halted;
    logic [31:0] stall_cycles;
    logic [31:0] redirect_count;

    int errors = 0;
    int checks = 0;

    pc_unit #(
        .WIDTH    (16),
        .RESET_VEC(16'h0000),
        .STEP     (16'd2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_en        (stall_en),
        .redirect_en     (redirect_en),
        .redirect_pc     (redirect_pc),
        .halt_req        (halt_req),
        .pc_out          (pc_out),
        .pc_seq          (pc_seq),
        .fetch_valid     (fetch_valid),
        .redirect_pending(redirect_pending),
        .halted          (halted),
        .stall_cycles    (stall_cycles),
        .redirect_count  (redirect_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [15:0] rpc, input logic h);
        stall_en    = s;
        redirect_en = r;
        redirect_pc = rpc;
        halt_req    = h;
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] s_exp, input logic [31:0] r_exp);
`ifdef PC_UNIT_PERF_EN
        check({tag, "_stall"}, stall_cycles, s_exp);
        check({tag, "_redir"}, redirect_count, r_exp);
`else
        check({tag, "_stall"}, stall_cycles, 32'd0);
        check({tag, "_redir"}, redirect_count, 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        #12;
        check("rst_pc", {16'h0, pc_out}, 32'h0000);
        check("rst_pend", {31'h0, redirect_pending}, 32'd0);
        check("rst_halt", {31'h0, halted}, 32'd0);
        rst = 1'b1;
        #1;
        check("rel_fv", {31'h0, fetch_valid}, 32'd1);

        // Free run: 2, 4, 6
        for (int i = 1; i <= 3; i++) begin
            step();
            check("run_pc", {16'h0, pc_out}, 32'(2 * i));
            check("run_fv", {31'h0, fetch_valid}, 32'd1);
        end

        // Immediate redirect, visible after one edge
        drive(1'b0, 1'b1, 16'h0010, 1'b0);
        step();
        check("redir_pc", {16'h0, pc_out}, 32'h0010);

        // Redirect during a two-cycle stall
        drive(1'b1, 1'b1, 16'h0100, 1'b0);
        step();
        check("stl1_pc", {16'h0, pc_out}, 32'h0010);
        check("stl1_pend", {31'h0, redirect_pending}, 32'd1);
        check("stl1_fv", {31'h0, fetch_valid}, 32'd0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        step();
        check("stl2_pc", {16'h0, pc_out}, 32'h0010);
        check("stl2_pend", {31'h0, redirect_pending}, 32'd1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        check("rel_pc", {16'h0, pc_out}, 32'h0100);
        check("rel_pend", {31'h0, redirect_pending}, 32'd0);
        check("rel_fv2", {31'h0, fetch_valid}, 32'd1);

        // Two redirects in one stall: newest wins
        drive(1'b1, 1'b1, 16'h0200, 1'b0);
        step();
        drive(1'b1, 1'b1, 16'h0300, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        check("two_pc", {16'h0, pc_out}, 32'h0300);
        check_cnt("cnt_a", 32'd4, 32'd4);

        // Redirect beats halt, then halt alone
        drive(1'b0, 1'b1, 16'h0040, 1'b0);
        step();
        check("h_pre_pc", {16'h0, pc_out}, 32'h0040);
        drive(1'b0, 1'b1, 16'h0080, 1'b1);
        step();
        check("h_sq_pc", {16'h0, pc_out}, 32'h0080);
        check("h_sq_halt", {31'h0, halted}, 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        step();
        check("h_halt", {31'h0, halted}, 32'd1);
        check("h_pc", {16'h0, pc_out}, 32'h0080);
        check("h_fv", {31'h0, fetch_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 1'b1, 16'h1234, 1'b0);
            step();
            check("hz_pc", {16'h0, pc_out}, 32'h0080);
            check("hz_halt", {31'h0, halted}, 32'd1);
            check("hz_pend", {31'h0, redirect_pending}, 32'd0);
        end
        check_cnt("cnt_b", 32'd4, 32'd6);

        // Reset out of HALTED
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        rst = 1'b0;
        #2;
        check("hrst_halt", {31'h0, halted}, 32'd0);
        rst = 1'b1;

        // Wraparound
        drive(1'b0, 1'b1, 16'hFFFE, 1'b0);
        step();
        check("wr_pc", {16'h0, pc_out}, 32'hFFFE);
        check("wr_seq", {16'h0, pc_seq}, 32'h0000);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        step();
        check("wr_next", {16'h0, pc_out}, 32'h0000);
        check("wr_seq2", {16'h0, pc_seq}, 32'h0002);

        // Pending redirect squashes a halt on release
        drive(1'b1, 1'b1, 16'h0600, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        step();
        check("ph_pc", {16'h0, pc_out}, 32'h0600);
        check("ph_halt", {31'h0, halted}, 32'd0);

        // Reset mid-stall with a pending redirect
        drive(1'b1, 1'b1, 16'h0500, 1'b0);
        step();
        check("ms_pend", {31'h0, redirect_pending}, 32'd1);
        check_cnt("cnt_c", 32'd2, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("ms_pc", {16'h0, pc_out}, 32'h0000);
        check("ms_pend0", {31'h0, redirect_pending}, 32'd0);
        check_cnt("cnt_rst", 32'd0, 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        #2;
        rst = 1'b1;
        step();
        check("post_pc", {16'h0, pc_out}, 32'h0002);
        check("post_fv", {31'h0, fetch_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the fetch stage; successor to the fixed 16-bit, stall-only PC register.
- Adds a configurable width, reset vector and increment, and an internal sequential increment.
- Adds a redirect input (branch/jump) with a pending-redirect buffer, so a redirect arriving during a stall is not lost.
- Adds a halt state machine. Feeds the instruction-memory address and the IF/ID pipeline register.

Parameters:
- WIDTH, 16, PC width in bits.
- RESET_VEC, 0, PC value loaded on reset.
- STEP, 2, sequential increment added per advancing cycle.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- stall_en  input  1  1 = hold PC this cycle
- redirect_en  input  1  1 = load redirect_pc (taken branch/jump)
- redirect_pc  input  WIDTH  redirect target
- halt_req  input  1  HLT decoded at the current PC
- pc_out  output  WIDTH  current fetch address
- pc_seq  output  WIDTH  pc_out+STEP mod 2^WIDTH, combinational (link value)
- fetch_valid  output  1  pc_out is a valid fetch this cycle
- redirect_pending  output  1  a buffered redirect is waiting
- halted  output  1  unit is in HALTED
- stall_cycles  output  32  perf counter (see Optional Feature)
- redirect_count  output  32  perf counter (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous, any state, any cycle):
  - pc_out=RESET_VEC, state=RUN, pending valid=0, pending pc=0, counters=0.
  - After release: fetch_valid=1, halted=0, redirect_pending=0.
- States: RUN and HALTED. Pending-redirect register: pend_v, pend_pc.
- RUN, per rising edge, first matching rule applies:
  1. redirect_en=1 and stall_en=0: pc<=redirect_pc; pend_v<=0. Any older pending redirect is discarded.
  2. redirect_en=1 and stall_en=1: pc holds; pend_pc<=redirect_pc; pend_v<=1. A newer redirect overwrites an older pending one.
  3. stall_en=0 and pend_v=1: pc<=pend_pc; pend_v<=0.
  4. stall_en=0 and halt_req=1: state<=HALTED; pc holds (stays at the HLT address).
  5. stall_en=0: pc<=pc+STEP, truncated to WIDTH bits (wraps, e.g. 0xFFFE+2=0x0000).
  6. stall_en=1: pc and pend_v hold.
- Priority summary:
  - Redirect beats halt in the same cycle: the halt is squashed as wrong-path.
  - halt_req is ignored while stall_en=1, and in any cycle where pend_v=1 or redirect_en=1.
- HALTED:
  - pc frozen; redirect_en, stall_en and halt_req ignored; pend_v forced to 0.
  - Exit only through reset.
- Outputs:
  - fetch_valid = (state==RUN) and pend_v==0. Combinational; low while a pending redirect makes pc_out wrong-path.
  - redirect_pending = pend_v. halted = (state==HALTED).
- Latency: a redirect accepted with stall_en=0 is visible on pc_out one cycle later.
- redirect_pc is loaded unmodified; there is no alignment masking.

Optional Feature:
- Macro: PC_UNIT_PERF_EN.
- Defined:
  - stall_cycles increments on every RUN cycle with stall_en=1.
  - redirect_count increments on every redirect_en=1 cycle in RUN, whether accepted immediately or buffered.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Not defined: both outputs are tied to 0 and no counter flops are built. Port list is unchanged.

Test Plan:
- Reset then 3 free-run cycles (WIDTH=16, RESET_VEC=0, STEP=2) -> pc_out 0x0000, 0x0002, 0x0004, 0x0006; fetch_valid=1 throughout.
- pc=0x0010, stall_en=1 for 2 cycles with redirect_en=1, redirect_pc=0x0100 in the first of them -> pc holds 0x0010; redirect_pending=1 and fetch_valid=0 from the next cycle; first unstalled edge loads 0x0100; redirect_pending=0.
- Two redirects during one stall (0x0200, then 0x0300) -> after stall release pc_out=0x0300.
- pc=0x0040, halt_req=1 and redirect_en=1 (0x0080) in the same cycle -> pc=0x0080, halted=0. Next cycle halt_req=1 alone -> halted=1; pc stays 0x0080 for 5 more cycles despite redirect_en=1.
- pc=0xFFFE, no stall -> next pc_out=0x0000; pc_seq at 0xFFFE reads 0x0000.
- rst asserted mid-stall with pend_v=1 -> pc_out=RESET_VEC immediately (before the next clock edge); redirect_pending=0; with PC_UNIT_PERF_EN defined, counters read 0 after a counted stall and redirect.
